bcmac_dot5_acc: RTL and testbench

Single-clock dot-product accumulator in the read-clock domain, directly downstream of the 4-bit-in / 20-bit-out transposing register file. It pops 20-bit words (five unsigned 4-bit activations) from the register file, multiplies each lane by a locally held 4-bit weight, and accumulates ACC_LEN words into one result. The result is then presented on a valid/ready output port.

---
 rtl/bcmac_pkg.sv | 16 +
 rtl/bcmac_dot5_acc_if.sv | 34 +++
 rtl/bcmac_dot5_b4.sv | 27 ++
 rtl/bcmac_dot5_acc.sv | 107 ++++++++++
 tb/tb_bcmac_dot5_acc.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/bcmac_pkg.sv
// rtl/bcmac_pkg.sv - shared widths and FSM state type for the dot-product accumulator
package bcmac_pkg;

  localparam int LANES  = 5;
  localparam int LANE_W = 4;
  localparam int WORD_W = 20;
  localparam int PROD_W = 8;
  localparam int SUM_W  = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/bcmac_dot5_acc_if.sv
// rtl/bcmac_dot5_acc_if.sv - register-file pop port and result valid/ready port
interface bcmac_dot5_acc_if #(
  parameter int OUT_W = 24
);
  import bcmac_pkg::*;

  logic              rf_empty;
  logic              r_en;
  logic [WORD_W-1:0] r_data;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;

  // accumulator side
  modport master (
    output r_en,
    output out_valid,
    output out_data,
    input  rf_empty,
    input  r_data,
    input  out_ready
  );

  // register file / result consumer side
  modport slave (
    input  r_en,
    input  out_valid,
    input  out_data,
    output rf_empty,
    output r_data,
    output out_ready
  );

endinterface

// File: rtl/bcmac_dot5_b4.sv
// rtl/bcmac_dot5_b4.sv - five-lane 4x4 unsigned multiply with summing tree
module bcmac_dot5_b4
  import bcmac_pkg::*;
(
  input  logic [WORD_W-1:0] data,
  input  logic [WORD_W-1:0] weight,
  output logic [SUM_W-1:0]  sum
);

  logic [PROD_W-1:0] prod [LANES];

  // per-lane products, operands widened first so the product keeps all 8 bits
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod[i] = PROD_W'(data[i*LANE_W +: LANE_W]) * PROD_W'(weight[i*LANE_W +: LANE_W]);
    end
  end

  // lane sum; 5 * 225 = 1125 fits in 11 bits
  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + SUM_W'(prod[i]);
    end
  end

endmodule

// File: rtl/bcmac_dot5_acc.sv
// rtl/bcmac_dot5_acc.sv - pops ACC_LEN words, accumulates weighted lane sums, presents result
module bcmac_dot5_acc
  import bcmac_pkg::*;
#(
  parameter int ACC_LEN = 8,
  parameter int OUT_W   = 24
) (
  input  logic              clk_r,
  input  logic              rst_n,
  input  logic              start,
  input  logic              w_load,
  input  logic [WORD_W-1:0] w_vec,
  output logic              busy,
  bcmac_dot5_acc_if.master  bus
);

  localparam int CNT_W = $clog2(ACC_LEN + 1);
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(ACC_LEN);

  generate
    if (ACC_LEN < 2 || ACC_LEN > 256) begin : g_bad_acc_len
      $error("bcmac_dot5_acc: ACC_LEN must be in 2..256");
    end
    if (OUT_W < SUM_W + $clog2(ACC_LEN)) begin : g_bad_out_w
      $error("bcmac_dot5_acc: OUT_W too narrow for ACC_LEN lane sums");
    end
  endgenerate

  state_t            state;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  recv_cnt;
  logic              rd_pend;
  logic [WORD_W-1:0] weights;
  logic [OUT_W-1:0]  acc;
  logic [OUT_W-1:0]  out_data_q;
  logic              out_valid_q;
  logic              r_en;
  logic [SUM_W-1:0]  lane_sum;

  bcmac_dot5_b4 u_dot (
    .data   (bus.r_data),
    .weight (weights),
    .sum    (lane_sum)
  );

  // pop whenever running, data available and not all words issued yet
  assign r_en          = (state == RUN) & ~bus.rf_empty & (issue_cnt < LEN_C);
  assign bus.r_en      = r_en;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = (state != IDLE);

  // control FSM with counters, weight register, accumulator and registered result
  always_ff @(posedge clk_r) begin
    if (!rst_n) begin
      state       <= IDLE;
      issue_cnt   <= '0;
      recv_cnt    <= '0;
      rd_pend     <= 1'b0;
      weights     <= '0;
      acc         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (w_load) begin
            weights <= w_vec;
          end
          if (start) begin
            state     <= RUN;
            acc       <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            rd_pend   <= 1'b0;
          end
        end
        RUN: begin
          if (r_en) begin
            issue_cnt <= issue_cnt + 1'b1;
          end
          rd_pend <= r_en;
          if (rd_pend) begin
            acc      <= acc + OUT_W'(lane_sum);
            recv_cnt <= recv_cnt + 1'b1;
          end
          // nothing is in flight once all words are received, so acc is final
          if (recv_cnt == LEN_C) begin
            state       <= OUT;
            out_valid_q <= 1'b1;
            out_data_q  <= acc;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcmac_dot5_acc.sv
// tb/tb_bcmac_dot5_acc.sv - randomized self-checking bench for bcmac_dot5_acc
module tb_bcmac_dot5_acc;
  import bcmac_pkg::*;

  localparam int ACC_LEN = 8;
  localparam int OUT_W   = 24;

  logic        clk_r  = 1'b0;
  logic        rst_n  = 1'b0;
  logic        start  = 1'b0;
  logic        w_load = 1'b0;
  logic [19:0] w_vec  = '0;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [19:0] model_w = '0;
  int got;

  bcmac_dot5_acc_if #(.OUT_W(OUT_W)) bus ();

  bcmac_dot5_acc #(.ACC_LEN(ACC_LEN), .OUT_W(OUT_W)) dut (
    .clk_r  (clk_r),
    .rst_n  (rst_n),
    .start  (start),
    .w_load (w_load),
    .w_vec  (w_vec),
    .busy   (busy),
    .bus    (bus)
  );

  always #5 clk_r = ~clk_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference: sum over lanes of activation nibble times weight nibble
  function automatic int dot5(input logic [19:0] a, input logic [19:0] w);
    int s;
    logic [3:0] an, wn;
    s = 0;
    for (int i = 0; i < 5; i++) begin
      an = a[4*i +: 4];
      wn = w[4*i +: 4];
      s += int'(an) * int'(wn);
    end
    return s;
  endfunction

  // one full result; entered and left at 1 time unit after a rising edge
  task automatic do_run(input string tag, input bit load, input logic [19:0] wv,
                        input bit rnd, input logic [19:0] word, input int empty_pct,
                        input int hold, output int result);
    int exp_sum, pops, cyc, bad;
    bit pop, seen, r_en_bad;
    logic [19:0] wd;
    logic [31:0] held;
    exp_sum = 0; pops = 0; cyc = 0; seen = 0; r_en_bad = 0; bad = 0;
    if (load) begin
      w_load = 1'b1;
      w_vec  = wv;
      model_w = wv;
    end
    start = 1'b1;
    bus.out_ready = (hold == 0);
    @(posedge clk_r); #1;
    start = 1'b0;
    w_load = 1'b0;
    while (!seen && cyc < 400) begin
      bus.rf_empty = ($urandom_range(99) < empty_pct);
      @(negedge clk_r);
      if (bus.r_en && bus.rf_empty) r_en_bad = 1;
      if (bus.out_valid) begin
        seen = 1;
      end else begin
        pop = bus.r_en;
        @(posedge clk_r); cyc++; #1;
        if (pop) begin
          wd = rnd ? 20'($urandom) : word;
          bus.r_data = wd;
          exp_sum += dot5(wd, model_w);
          pops++;
        end else begin
          bus.r_data = 20'($urandom);
        end
      end
    end
    result = int'(bus.out_data);
    chk({tag, "_valid_seen"}, 32'(seen), 1);
    chk({tag, "_ren_vs_empty"}, 32'(r_en_bad), 0);
    chk({tag, "_pops"}, pops, ACC_LEN);
    chk({tag, "_sum"}, bus.out_data, exp_sum);
    if (empty_pct == 0) chk({tag, "_latency"}, cyc, ACC_LEN + 2);
    if (hold > 0) begin
      held = 32'(bus.out_data);
      @(posedge clk_r); #1;
      for (int k = 0; k < hold; k++) begin
        bus.rf_empty = 1'b0;
        if (k == 5) start = 1'b1;
        if (k == 8) begin
          w_load = 1'b1;
          w_vec  = 20'($urandom);
        end
        @(negedge clk_r);
        if (!bus.out_valid || 32'(bus.out_data) !== held || bus.r_en || !busy) bad++;
        @(posedge clk_r); #1;
        start = 1'b0;
        w_load = 1'b0;
      end
      chk({tag, "_hold_stable"}, bad, 0);
      bus.out_ready = 1'b1;
      @(negedge clk_r);
      chk({tag, "_valid_at_hs"}, 32'(bus.out_valid), 1);
    end
    @(posedge clk_r); #1;
    bus.out_ready = 1'b0;
    @(negedge clk_r);
    chk({tag, "_busy_after"}, 32'(busy), 0);
    chk({tag, "_valid_after"}, 32'(bus.out_valid), 0);
    @(posedge clk_r); #1;
  endtask

  task automatic reset_mid_run(input logic [19:0] wv);
    int pops, cyc;
    bit pop;
    pops = 0; cyc = 0;
    w_load = 1'b1; w_vec = wv; model_w = wv; start = 1'b1;
    @(posedge clk_r); #1;
    start = 1'b0; w_load = 1'b0;
    while (pops < 3 && cyc < 50) begin
      bus.rf_empty = 1'b0;
      @(negedge clk_r);
      pop = bus.r_en;
      @(posedge clk_r); cyc++; #1;
      if (pop) begin
        pops++;
        bus.r_data = 20'($urandom);
      end
    end
    chk("rst_mid_pops", pops, 3);
    rst_n = 1'b0;
    @(posedge clk_r); #1;
    rst_n = 1'b1;
    model_w = '0;
    bus.rf_empty = 1'b0;
    chk("rst_mid_ren", 32'(bus.r_en), 0);
    chk("rst_mid_valid", 32'(bus.out_valid), 0);
    chk("rst_mid_data", bus.out_data, 0);
    chk("rst_mid_busy", 32'(busy), 0);
  endtask

  initial begin
    bus.rf_empty  = 1'b0;
    bus.out_ready = 1'b0;
    bus.r_data    = '0;
    repeat (3) @(posedge clk_r);
    #1;
    chk("reset_valid", 32'(bus.out_valid), 0);
    chk("reset_data", bus.out_data, 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_ren", 32'(bus.r_en), 0);
    rst_n = 1'b1;
    @(posedge clk_r); #1;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_ren", 32'(bus.r_en), 0);

    do_run("basic", 1, 20'h11111, 0, 20'h11111, 0, 0, got);
    chk("basic_const", got, 40);
    do_run("max", 1, 20'hFFFFF, 0, 20'hFFFFF, 0, 0, got);
    chk("max_const", got, 9000);
    do_run("lane0", 1, 20'h00001, 0, 20'h0000A, 0, 0, got);
    chk("lane0_const", got, 80);
    do_run("lane4", 0, 20'h0, 0, 20'hA0000, 0, 0, got);
    chk("lane4_const", got, 0);

    for (int r = 0; r < 6; r++) begin
      do_run("rand_empty", 1, 20'($urandom), 1, 20'h0, 40, 0, got);
    end

    do_run("backpressure", 1, 20'($urandom), 1, 20'h0, 20, 20, got);
    do_run("frozen_w", 0, 20'h0, 1, 20'h0, 30, 0, got);

    reset_mid_run(20'hFFFFF);
    do_run("post_rst_zero_w", 0, 20'h0, 0, 20'hFFFFF, 0, 0, got);
    chk("post_rst_zero_const", got, 0);
    do_run("post_rst_fresh", 1, 20'h23456, 1, 20'h0, 25, 0, got);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
